dacscan: RTL and testbench
==========================

# dacscan

Multi-channel DAC/comparator scanner that produces the DAC-channel readback data consumed by the xdata register block. It sits between that block and the analog front-end. It owns the DAC value registers (DACV8..15), DACEN and SAREN, and drives the shared 8-bit DAC and channel mux. It round-robins over enabled channels in one of two modes: a plain compare mode, or an 8-step successive-approximation (SAR) mode that writes its result back into the channel's DAC value.

## Interface
- `SETTLE`, default 6: DAC/comparator settle cycles per comparison; legal range 3..255. Covers the 2-flop comparator synchronizer.
- `clk`  in  1  system clock
- `rrstz`  in  1  reset, asynchronous, active-low
- `regx_wdat`  in  8  write data from the xdata register write path
- `regx_wrdac`  in  10  write strobes, one cycle each: [0] DACEN, [1] SAREN, [2+i] DAC value of channel i
- `ana_comp`  in  1  raw comparator output, asynchronous; 1 = input ≥ DAC
- `dac_r_vs`  out  64  channel i value at [8*i+:8]
- `r_dac_en`  out  8  channel enable register
- `r_sar_en`  out  8  per-channel SAR-mode register
- `dac_comp`  out  8  last comparison result per channel
- `dac_v`  out  8  code driven to the analog DAC
- `dac_sel`  out  3  analog mux channel
- `busy`  out  1  scanner not idle

## Operation
- Reset values: all registers 0, `dac_v` 0, `dac_sel` 0, `busy` 0, state IDLE. The internal current channel `cur` resets to 7, so the first pick is channel 0.
- `ana_comp` passes through two flops to give `comp_s`. Nothing else uses the raw input.
- **State IDLE**
  - Leave IDLE when `r_dac_en` ≠ 0; go to NEXT.
- **State NEXT** (1 cycle)
  - Pick the first enabled channel, searching `cur+1`, `cur+2`, … with wrap mod 8.
  - If none is enabled, go to IDLE. `dac_v` and `dac_sel` hold.
  - Otherwise set `cur`/`dac_sel` to the channel, latch its SAREN bit as `mode`, and clear `cnt` to 0.
  - Load `dac_v`: in compare mode, `dac_r_vs[cur]`; in SAR mode, trial = 0x80 with bit index k = 7.
  - Go to CONV.
- **State CONV**
  - `cnt` increments each cycle. At `cnt == SETTLE-1`, `comp_s` is sampled.
  - Compare mode: `dac_comp[cur]` ← `comp_s`; go to NEXT.
  - SAR mode: if `comp_s` = 0, clear bit k of the trial.
    - If k > 0: set bit k-1, decrement k, clear `cnt`, stay in CONV.
    - If k = 0: `dac_r_vs[cur]` ← final trial, `dac_comp[cur]` ← `comp_s`, go to NEXT.
  - Intermediate SAR trials appear only on `dac_v`, never in `dac_r_vs`.
- **Register writes** (applied in the strobe cycle, visible on outputs the next cycle)
  - `regx_wrdac[2+i]` writes channel i.
    - If i = `cur` in compare mode: `dac_v` reloads with the new value and `cnt` restarts.
    - If i = `cur` in SAR mode: the conversion aborts and goes to NEXT. The written value is kept; no result write-back occurs.
    - If the cycle is also the SAR completion for i, the register write wins.
  - `regx_wrdac[0]`: if the new enable clears bit `cur` while in CONV, the channel aborts to NEXT and `dac_comp[cur]` holds.
  - `regx_wrdac[1]`: takes effect at the next NEXT. The channel currently converting keeps its latched `mode`.
- Disabled channels hold `dac_r_vs` and `dac_comp`.

## Timing
- Compare channel: SETTLE CONV cycles + 1 NEXT cycle = SETTLE+1 per channel.
- SAR channel: 8·SETTLE + 1.
- `dac_comp` and `dac_r_vs` update on the clock edge ending the sample cycle.
- Comparator to sample latency: 2 sync cycles, always inside SETTLE.
- `busy` = (state ≠ IDLE), registered with the state.
- Reset mid-conversion: immediate return to reset values. No partial SAR result survives.

## Structure
- Shared package `dacscan_pkg`:
  - state enum {IDLE, NEXT, CONV}
  - `NCH = 8`
  - strobe index constants `WR_DACEN = 0`, `WR_SAREN = 1`, `WR_DACV0 = 2`
- One sub-module, `rr_pick8`: combinational rotating priority picker.
  - Inputs: 8-bit request, 3-bit last.
  - Outputs: 3-bit pick, valid.

## Test plan
- Reset, SETTLE = 4: all outputs 0, `busy` = 0.
  - Write DACEN = 0x00: stays IDLE, `busy` stays 0.
- Compare mode: write ch2 value = 0x40, hold `ana_comp` = 1, DACEN = 0x04.
  - `dac_sel` = 2, `dac_v` = 0x40.
  - `dac_comp[2]` = 1 five cycles after NEXT, repeating every 5 cycles.
- SAR mode: comparator model (input 0x5A ≥ `dac_v`), SAREN = 0x01, DACEN = 0x01.
  - After 33 cycles, `dac_r_vs[7:0]` = 0x5A.
  - `dac_v` trial sequence: 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A, 0x5B.
- Round-robin: DACEN = 0x42, compare mode.
  - `dac_sel` sequence: 1, 6, 1, 6, …
  - Clear bit 6 while ch6 converts: next pick is 1 and `dac_comp[6]` holds.
- SAR abort: write ch0 = 0x33 at step k = 3.
  - Scanner moves to next channel.
  - `dac_r_vs[7:0]` = 0x33, not a SAR result.
- Disable and reset mid-run:
  - DACEN ← 0 mid-CONV: IDLE within 2 cycles, `busy` = 0.
  - `rrstz` low mid-SAR: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/dacscan_pkg.sv
// dacscan_pkg: scanner states, channel count and write-strobe bit positions shared by dacscan RTL and bench
package dacscan_pkg;
  typedef enum logic [1:0] {IDLE, NEXT, CONV} state_t;
  localparam int NCH = 8;
  localparam int WR_DACEN = 0;
  localparam int WR_SAREN = 1;
  localparam int WR_DACV0 = 2;
endpackage

// File: rtl/dacscan_if.sv
// dacscan_if: register-side bus; master drives regx_wdat/regx_wrdac, slave returns dac_r_vs/r_dac_en/r_sar_en/dac_comp
interface dacscan_if;
  import dacscan_pkg::*;
  logic [7:0] regx_wdat;
  logic [WR_DACV0+NCH-1:0] regx_wrdac;
  logic [8*NCH-1:0] dac_r_vs;
  logic [NCH-1:0] r_dac_en;
  logic [NCH-1:0] r_sar_en;
  logic [NCH-1:0] dac_comp;
  modport master (output regx_wdat, regx_wrdac, input dac_r_vs, r_dac_en, r_sar_en, dac_comp);
  modport slave (input regx_wdat, regx_wrdac, output dac_r_vs, r_dac_en, r_sar_en, dac_comp);
endinterface

// File: rtl/dacscan_rr_pick8.sv
// rr_pick8: rotating priority picker; req_i requests, last_i previous pick -> pick_o first request after last_i, valid_o any request
module rr_pick8 (
  input  logic [7:0] req_i,
  input  logic [2:0] last_i,
  output logic [2:0] pick_o,
  output logic       valid_o
);
  always_comb begin
    pick_o = last_i;
    valid_o = |req_i;
    for (int j = 8; j >= 1; j--)
      if (req_i[3'(int'(last_i) + j)]) pick_o = 3'(int'(last_i) + j);
  end
endmodule

// File: rtl/dacscan.sv
// dacscan: round-robin DAC/comparator scanner (compare or 8-step SAR); clk, rrstz async low reset, rx register bus, ana_comp in, dac_v/dac_sel/busy out
module dacscan
  import dacscan_pkg::*;
#(
  parameter int SETTLE = 6
) (
  input  logic           clk,
  input  logic           rrstz,
  dacscan_if.slave       rx,
  input  logic           ana_comp,
  output logic [7:0]     dac_v,
  output logic [2:0]     dac_sel,
  output logic           busy
);
  state_t state_q, state_d;
  logic [2:0] cur_q, cur_d, sel_q, sel_d, k_q, k_d, pick;
  logic [7:0] cnt_q, cnt_d, dacv_q, dacv_d, trial;
  logic [NCH-1:0][7:0] vals_q, vals_d;
  logic [NCH-1:0] en_q, en_d, sar_q, sar_d, comp_q, comp_d, wr_v;
  logic [1:0] sync_q;
  logic mode_q, mode_d, pvalid, comp_s;
  rr_pick8 u_pick (.req_i(en_q), .last_i(cur_q), .pick_o(pick), .valid_o(pvalid));
  assign comp_s = sync_q[1];
  assign wr_v = rx.regx_wrdac[WR_DACV0 +: NCH];
  assign trial = comp_s ? dacv_q : dacv_q & ~(8'h1 << k_q);
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    sel_d = sel_q;
    mode_d = mode_q;
    cnt_d = cnt_q;
    k_d = k_q;
    dacv_d = dacv_q;
    comp_d = comp_q;
    en_d = rx.regx_wrdac[WR_DACEN] ? rx.regx_wdat : en_q;
    sar_d = rx.regx_wrdac[WR_SAREN] ? rx.regx_wdat : sar_q;
    for (int i = 0; i < NCH; i++) vals_d[i] = wr_v[i] ? rx.regx_wdat : vals_q[i];
    unique case (state_q)
      IDLE: state_d = |en_q ? NEXT : IDLE;
      NEXT: begin
        state_d = pvalid ? CONV : IDLE;
        if (pvalid) begin
          cur_d = pick;
          sel_d = pick;
          mode_d = sar_q[pick];
          cnt_d = '0;
          k_d = 3'd7;
          dacv_d = sar_q[pick] ? 8'h80 : vals_d[pick];
        end
      end
      CONV: begin
        cnt_d = cnt_q + 8'd1;
        if ((rx.regx_wrdac[WR_DACEN] && !rx.regx_wdat[cur_q]) || (wr_v[cur_q] && mode_q)) begin
          state_d = NEXT;
        end else if (wr_v[cur_q]) begin
          dacv_d = rx.regx_wdat;
          cnt_d = '0;
        end else if (cnt_q == 8'(SETTLE - 1)) begin
          if (mode_q && k_q != 3'd0) begin
            dacv_d = trial | (8'h1 << (k_q - 3'd1));
            k_d = k_q - 3'd1;
            cnt_d = '0;
          end else begin
            state_d = NEXT;
            comp_d[cur_q] = comp_s;
            if (mode_q) begin
              vals_d[cur_q] = trial;
              dacv_d = trial;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rrstz) begin
    if (!rrstz) begin
      state_q <= IDLE;
      cur_q <= 3'd7;
      sel_q <= '0;
      mode_q <= 1'b0;
      cnt_q <= '0;
      k_q <= '0;
      dacv_q <= '0;
      vals_q <= '0;
      en_q <= '0;
      sar_q <= '0;
      comp_q <= '0;
      sync_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      sel_q <= sel_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
      dacv_q <= dacv_d;
      vals_q <= vals_d;
      en_q <= en_d;
      sar_q <= sar_d;
      comp_q <= comp_d;
      sync_q <= {sync_q[0], ana_comp};
    end
  end
  assign rx.dac_r_vs = vals_q;
  assign rx.r_dac_en = en_q;
  assign rx.r_sar_en = sar_q;
  assign rx.dac_comp = comp_q;
  assign dac_v = dacv_q;
  assign dac_sel = sel_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_dacscan.sv
// tb_dacscan: self-checking bench for dacscan with register table, directed corner sequences and randomized scans against a schedule model
module tb_dacscan;
  import dacscan_pkg::*;
  localparam int S = 4;
  typedef struct {
    int         idx;
    logic [7:0] d;
    logic [63:0] vs;
    logic [7:0] sar;
  } vec_t;
  logic clk = 1'b0;
  logic rrstz = 1'b0;
  logic ana_comp;
  logic ana_const = 1'b0;
  logic use_tgt = 1'b0;
  logic [7:0] dac_v;
  logic [2:0] dac_sel;
  logic busy;
  logic [7:0] tgt [8];
  logic [7:0] val [8];
  logic [7:0] sar_seq [8] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
  vec_t vt [7];
  int tests = 0;
  int fails = 0;
  dacscan_if rx();
  dacscan #(.SETTLE(S)) dut (
    .clk(clk), .rrstz(rrstz), .rx(rx), .ana_comp(ana_comp),
    .dac_v(dac_v), .dac_sel(dac_sel), .busy(busy)
  );
  always #5 clk = ~clk;
  assign ana_comp = use_tgt ? (tgt[dac_sel] >= dac_v) : ana_const;
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input int idx, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx.regx_wdat = d;
    rx.regx_wrdac = 10'd1 << idx;
    @(posedge clk);
    #1;
    rx.regx_wrdac = '0;
  endtask
  task automatic do_reset;
    rrstz = 1'b0;
    use_tgt = 1'b0;
    ana_const = 1'b0;
    ticks(2);
    rrstz = 1'b1;
    ticks(1);
  endtask
  initial begin
    logic [7:0] en, sar, ecomp;
    logic [63:0] evs;
    int errs, d;
    vt[0] = '{2, 8'h11, 64'h0000000000000011, 8'h00};
    vt[1] = '{9, 8'hA5, 64'hA500000000000011, 8'h00};
    vt[2] = '{4, 8'h40, 64'hA500000000400011, 8'h00};
    vt[3] = '{1, 8'h81, 64'hA500000000400011, 8'h81};
    vt[4] = '{2, 8'hFF, 64'hA5000000004000FF, 8'h81};
    vt[5] = '{6, 8'h3C, 64'hA500003C004000FF, 8'h81};
    vt[6] = '{1, 8'h00, 64'hA500003C004000FF, 8'h00};
    for (int c = 0; c < 8; c++) tgt[c] = '0;
    rx.regx_wdat = '0;
    rx.regx_wrdac = '0;
    ticks(2);
    check("rst_vs", rx.dac_r_vs, 64'h0);
    check("rst_en", rx.r_dac_en, 8'h0);
    check("rst_sar", rx.r_sar_en, 8'h0);
    check("rst_comp", rx.dac_comp, 8'h0);
    check("rst_dacv", dac_v, 8'h0);
    check("rst_sel", dac_sel, 3'd0);
    check("rst_busy", busy, 1'b0);
    rrstz = 1'b1;
    wr(WR_DACEN, 8'h00);
    ticks(3);
    check("en0_busy", busy, 1'b0);
    for (int i = 0; i < 7; i++) begin
      wr(vt[i].idx, vt[i].d);
      ticks(1);
      check($sformatf("tbl%0d_vs", i), rx.dac_r_vs, vt[i].vs);
      check($sformatf("tbl%0d_sar", i), rx.r_sar_en, vt[i].sar);
      check($sformatf("tbl%0d_busy", i), busy, 1'b0);
    end
    do_reset();
    wr(WR_DACV0 + 2, 8'h40);
    ana_const = 1'b1;
    wr(WR_DACEN, 8'h04);
    ticks(2);
    check("cmp_busy", busy, 1'b1);
    ticks(1);
    check("cmp_sel", dac_sel, 3'd2);
    check("cmp_dacv", dac_v, 8'h40);
    ticks(3);
    check("cmp_comp_pre", rx.dac_comp, 8'h00);
    ticks(1);
    check("cmp_comp_set", rx.dac_comp, 8'h04);
    ana_const = 1'b0;
    ticks(4);
    check("cmp_comp_hold", rx.dac_comp, 8'h04);
    ticks(1);
    check("cmp_comp_clr", rx.dac_comp, 8'h00);
    ticks(1);
    wr(WR_DACEN, 8'h00);
    ticks(1);
    check("dis_busy_next", busy, 1'b1);
    ticks(1);
    check("dis_idle", busy, 1'b0);
    do_reset();
    ana_const = 1'b1;
    wr(WR_DACEN, 8'h42);
    ticks(3);
    check("rr_sel1", dac_sel, 3'd1);
    ticks(5);
    check("rr_sel6", dac_sel, 3'd6);
    ticks(5);
    check("rr_sel1b", dac_sel, 3'd1);
    check("rr_comp", rx.dac_comp, 8'h42);
    ticks(1);
    ana_const = 1'b0;
    ticks(4);
    check("rr_sel6b", dac_sel, 3'd6);
    ticks(1);
    wr(WR_DACEN, 8'h02);
    ticks(2);
    check("rr_abort_sel", dac_sel, 3'd1);
    check("rr_abort_comp", rx.dac_comp, 8'h40);
    do_reset();
    tgt[0] = 8'h5A;
    use_tgt = 1'b1;
    wr(WR_SAREN, 8'h01);
    wr(WR_DACEN, 8'h01);
    ticks(2);
    for (int j = 0; j < 8; j++) begin
      ticks(j == 0 ? 1 : S);
      check($sformatf("sar_trial%0d", j), dac_v, sar_seq[j]);
    end
    ticks(3);
    check("sar_pre", rx.dac_r_vs[7:0], 8'h00);
    ticks(1);
    check("sar_res", rx.dac_r_vs[7:0], 8'h5A);
    check("sar_comp", rx.dac_comp, 8'h00);
    ticks(5);
    #2 rrstz = 1'b0;
    #1;
    check("arst_vs", rx.dac_r_vs, 64'h0);
    check("arst_en", rx.r_dac_en, 8'h0);
    check("arst_sar", rx.r_sar_en, 8'h0);
    check("arst_dacv", dac_v, 8'h0);
    check("arst_busy", busy, 1'b0);
    do_reset();
    tgt[0] = 8'h5A;
    tgt[1] = 8'h00;
    use_tgt = 1'b1;
    wr(WR_SAREN, 8'h01);
    wr(WR_DACEN, 8'h03);
    ticks(19);
    check("abort_k3", dac_v, 8'h58);
    wr(WR_DACV0, 8'h33);
    ticks(2);
    check("abort_sel", dac_sel, 3'd1);
    check("abort_vs", rx.dac_r_vs[7:0], 8'h33);
    ticks(4);
    check("abort_vs_hold", rx.dac_r_vs[7:0], 8'h33);
    check("abort_comp", rx.dac_comp, 8'h02);
    for (int t = 0; t < 6; t++) begin
      do_reset();
      use_tgt = 1'b1;
      for (int c = 0; c < 8; c++) begin
        val[c] = 8'($urandom);
        tgt[c] = 8'($urandom);
        wr(WR_DACV0 + c, val[c]);
      end
      sar = 8'($urandom);
      en = 8'($urandom_range(1, 255));
      wr(WR_SAREN, sar);
      wr(WR_DACEN, en);
      ticks(2);
      errs = 0;
      for (int c = 0; c < 8; c++) begin
        if (en[c]) begin
          d = sar[c] ? 8 * S + 1 : S + 1;
          repeat (d) begin
            @(negedge clk);
            if (dac_sel !== 3'(c) || busy !== 1'b1) errs++;
          end
        end
      end
      check($sformatf("rnd%0d_sched", t), 64'(errs), 64'd0);
      evs = '0;
      ecomp = '0;
      for (int c = 0; c < 8; c++) begin
        evs[8*c +: 8] = (en[c] && sar[c]) ? tgt[c] : val[c];
        ecomp[c] = en[c] && (sar[c] ? tgt[c][0] : tgt[c] >= val[c]);
      end
      check($sformatf("rnd%0d_vs", t), rx.dac_r_vs, evs);
      check($sformatf("rnd%0d_comp", t), rx.dac_comp, ecomp);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
